// File: rtl/imem_loader.sv
// imem_loader
// Program loader that fills the instruction memory read by the fetch unit.
// It takes a byte stream: a 16-bit big-endian word count followed by that
// many 16-bit big-endian instructions. Each instruction is written to
// consecutive addresses starting at 0.
//
// Ports:
//   clk_i          - clock, all state updates on the rising edge
//   rst_ni         - asynchronous active-low reset
//   start_i        - begin a load (honoured only in IDLE, DONE or ERR)
//   byte_in_i      - stream byte
//   byte_valid_i   - byte_in_i is valid
//   byte_ready_o   - loader accepts a byte this cycle
//   mem_we_o       - instruction-memory write strobe, one cycle per word
//   mem_addr_o     - write address
//   mem_wdata_o    - write data
//   words_loaded_o - number of words written in the current load
//   load_done_o    - image complete, held until next start or reset
//   error_o        - header count exceeds memory depth, held likewise
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [7:0]        byte_in_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_wdata_o,
    output logic [ADDR_W:0]   words_loaded_o,
    output logic              load_done_o,
    output logic              error_o
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       count_q;
    logic [7:0]        hi_q;
    logic [ADDR_W:0]   words_q;
    logic [ADDR_W:0]   words_inc;
    logic [15:0]       hdr_count;
    logic              byte_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_wdata_q;
    logic              load_done_q;
    logic              error_q;
    logic              accept;

    // byte_ready_q is a registered decode of the current state, so a
    // handshake can be evaluated without any combinational path from state.
    assign accept = byte_valid_i && byte_ready_q;

    // Next-state decision. The full header count is only known while the
    // low header byte is on the bus, so it is assembled here for the branch.
    always_comb begin
        state_d   = state_q;
        hdr_count = {count_q[15:8], byte_in_i};
        words_inc = words_q + 1'b1;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) state_d = HDR_HI;
            end
            HDR_HI: begin
                if (accept) state_d = HDR_LO;
            end
            HDR_LO: begin
                if (accept) begin
                    if (hdr_count == 16'd0)
                        state_d = DONE;
                    else if (32'(hdr_count) > DEPTH)
                        state_d = ERR;
                    else
                        state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) state_d = DATA_LO;
            end
            DATA_LO: begin
                if (accept) state_d = WRITE;
            end
            WRITE: begin
                if (32'(words_inc) == 32'(count_q))
                    state_d = DONE;
                else
                    state_d = DATA_HI;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs. words_q doubles as the write index:
    // it is the address of the next word and the count of words written.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            count_q      <= '0;
            hi_q         <= '0;
            words_q      <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            load_done_q  <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= (state_d == HDR_HI) || (state_d == HDR_LO) ||
                            (state_d == DATA_HI) || (state_d == DATA_LO);
            mem_we_q     <= (state_d == WRITE);
            load_done_q  <= (state_d == DONE);
            error_q      <= (state_d == ERR);
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start_i) words_q <= '0;
                end
                HDR_HI: begin
                    if (accept) count_q[15:8] <= byte_in_i;
                end
                HDR_LO: begin
                    if (accept) count_q[7:0] <= byte_in_i;
                end
                DATA_HI: begin
                    if (accept) hi_q <= byte_in_i;
                end
                DATA_LO: begin
                    if (accept) begin
                        mem_wdata_q <= {hi_q, byte_in_i};
                        mem_addr_q  <= words_q[ADDR_W-1:0];
                    end
                end
                WRITE: begin
                    words_q <= words_inc;
                end
                default: ;
            endcase
        end
    end

    assign byte_ready_o   = byte_ready_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign words_loaded_o = words_q;
    assign load_done_o    = load_done_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed bench for imem_loader built with a 16-word memory (ADDR_W = 4)
// so the oversize and full-depth images stay short.
module tb_imem_loader;

    localparam int ADDR_W = 4;

    logic              clk;
    logic              rstN;
    logic              start;
    logic [7:0]        byteIn;
    logic              byteValid;
    logic              byteReady;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [15:0]       memWdata;
    logic [ADDR_W:0]   wordsLoaded;
    logic              loadDone;
    logic              errorO;

    int checkCount = 0;
    int failCount  = 0;
    int cycleNum   = 0;

    int          wrCycle[$];
    logic [3:0]  wrAddr[$];
    logic [15:0] wrData[$];
    logic [15:0] expData[16];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .start_i        (start),
        .byte_in_i      (byteIn),
        .byte_valid_i   (byteValid),
        .byte_ready_o   (byteReady),
        .mem_we_o       (memWe),
        .mem_addr_o     (memAddr),
        .mem_wdata_o    (memWdata),
        .words_loaded_o (wordsLoaded),
        .load_done_o    (loadDone),
        .error_o        (errorO)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure spacing between write strobes
    always @(posedge clk) cycleNum <= cycleNum + 1;

    // Record every memory write, sampled on the falling edge
    always @(negedge clk) begin
        if (rstN === 1'b1 && memWe === 1'b1) begin
            wrCycle.push_back(cycleNum);
            wrAddr.push_back(memAddr);
            wrData.push_back(memWdata);
        end
    end

    // Hard time limit so the bench can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic [7:0] b);
        start     = s;
        byteValid = v;
        byteIn    = b;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Present a byte and hold it until the loader takes it. Returns in the
    // cycle after the accepting edge, with byteValid still high.
    task automatic sendByte(input logic [7:0] b);
        logic willAccept;
        logic taken;
        taken = 1'b0;
        applyStimulus(1'b0, 1'b1, b);
        for (int i = 0; i < 50; i++) begin
            willAccept = byteReady;
            stepCycle();
            if (willAccept) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) checkOutput("acceptTimeout", 32'd0, 32'd1);
    endtask

    task automatic startLoad();
        applyStimulus(1'b1, 1'b0, 8'h00);
        stepCycle();
        start = 1'b0;
        checkOutput("startReady", 32'(byteReady), 32'd1);
        checkOutput("startDoneClr", 32'(loadDone), 32'd0);
        checkOutput("startErrClr", 32'(errorO), 32'd0);
        checkOutput("startWordsClr", 32'(wordsLoaded), 32'd0);
    endtask

    task automatic clearLog();
        wrCycle.delete();
        wrAddr.delete();
        wrData.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Ready"}, 32'(byteReady), 32'd0);
        checkOutput({tag, "We"}, 32'(memWe), 32'd0);
        checkOutput({tag, "Addr"}, 32'(memAddr), 32'd0);
        checkOutput({tag, "Wdata"}, 32'(memWdata), 32'd0);
        checkOutput({tag, "Words"}, 32'(wordsLoaded), 32'd0);
        checkOutput({tag, "Done"}, 32'(loadDone), 32'd0);
        checkOutput({tag, "Err"}, 32'(errorO), 32'd0);
    endtask

    // Compare the write log with expData[0..n-1] at addresses 0..n-1
    task automatic verifyWrites(input string tag, input int n);
        checkOutput({tag, "Count"}, 32'(wrAddr.size()), 32'(n));
        for (int i = 0; i < n && i < wrAddr.size(); i++) begin
            checkOutput($sformatf("%sAddr%0d", tag, i), 32'(wrAddr[i]), 32'(i));
            checkOutput($sformatf("%sData%0d", tag, i), 32'(wrData[i]), 32'(expData[i]));
        end
    endtask

    // Directed test sequence
    initial begin
        logic [7:0] bpBytes[10];
        int         gaps;

        rstN = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Reset asserted mid-cycle with random inputs
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 8'($urandom));
            stepCycle();
        end
        #3;
        rstN = 1'b0;
        #1;
        checkAllZero("rstAsync");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 8'($urandom));
            stepCycle();
            checkAllZero("rstHold");
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        rstN = 1'b1;
        stepCycle();
        clearLog();

        // Basic 3-word load, byteValid held high throughout
        $display("[TB] basic 3-word load");
        expData[0] = 16'h1234;
        expData[1] = 16'hABCD;
        expData[2] = 16'h0001;
        startLoad();
        sendByte(8'h00);
        sendByte(8'h03);
        sendByte(8'h12);
        sendByte(8'h34);
        checkOutput("basicWe0", 32'(memWe), 32'd1);
        checkOutput("basicWords0", 32'(wordsLoaded), 32'd0);
        sendByte(8'hAB);
        sendByte(8'hCD);
        sendByte(8'h00);
        sendByte(8'h01);
        checkOutput("basicLastWe", 32'(memWe), 32'd1);
        checkOutput("basicLastReady", 32'(byteReady), 32'd0);
        checkOutput("basicWordsPre", 32'(wordsLoaded), 32'd2);
        checkOutput("basicDonePre", 32'(loadDone), 32'd0);
        byteValid = 1'b0;
        stepCycle();
        checkOutput("basicDone", 32'(loadDone), 32'd1);
        checkOutput("basicWords", 32'(wordsLoaded), 32'd3);
        checkOutput("basicWeOff", 32'(memWe), 32'd0);
        checkOutput("basicAddrHold", 32'(memAddr), 32'd2);
        checkOutput("basicDataHold", 32'(memWdata), 32'h0001);
        verifyWrites("basic", 3);
        if (wrCycle.size() == 3) begin
            checkOutput("basicSpacing01", 32'(wrCycle[1] - wrCycle[0]), 32'd3);
            checkOutput("basicSpacing12", 32'(wrCycle[2] - wrCycle[1]), 32'd3);
        end

        // Stray bytes in DONE are not accepted
        byteValid = 1'b1;
        stepCycle();
        checkOutput("doneStrayReady", 32'(byteReady), 32'd0);
        checkOutput("doneStrayHold", 32'(loadDone), 32'd1);
        byteValid = 1'b0;

        // Empty image
        $display("[TB] empty image");
        clearLog();
        startLoad();
        sendByte(8'h00);
        sendByte(8'h00);
        byteValid = 1'b0;
        checkOutput("emptyDone", 32'(loadDone), 32'd1);
        checkOutput("emptyWords", 32'(wordsLoaded), 32'd0);
        checkOutput("emptyReady", 32'(byteReady), 32'd0);
        stepCycle();
        stepCycle();
        checkOutput("emptyWrites", 32'(wrAddr.size()), 32'd0);

        // Oversize image: 17 words into a 16-word memory
        $display("[TB] oversize image");
        clearLog();
        startLoad();
        sendByte(8'h00);
        sendByte(8'h11);
        checkOutput("overErr", 32'(errorO), 32'd1);
        checkOutput("overReady", 32'(byteReady), 32'd0);
        checkOutput("overDone", 32'(loadDone), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 8'($urandom));
            stepCycle();
        end
        checkOutput("overReadyHold", 32'(byteReady), 32'd0);
        checkOutput("overErrHold", 32'(errorO), 32'd1);
        checkOutput("overWrites", 32'(wrAddr.size()), 32'd0);
        byteValid = 1'b0;

        // Full-depth image of exactly 16 words
        $display("[TB] full-depth image");
        for (int i = 0; i < 16; i++) expData[i] = {8'(8'h10 + i), 8'(8'hF0 - i)};
        clearLog();
        startLoad();
        sendByte(8'h00);
        sendByte(8'h10);
        for (int i = 0; i < 16; i++) begin
            sendByte(expData[i][15:8]);
            sendByte(expData[i][7:0]);
        end
        byteValid = 1'b0;
        stepCycle();
        checkOutput("fullDone", 32'(loadDone), 32'd1);
        checkOutput("fullErr", 32'(errorO), 32'd0);
        checkOutput("fullWords", 32'(wordsLoaded), 32'd16);
        verifyWrites("full", 16);

        // Backpressure and gaps, with a start pulse mid-load that is ignored
        $display("[TB] backpressure and gaps");
        expData[0] = 16'hC0DE;
        expData[1] = 16'h5A5A;
        expData[2] = 16'h0102;
        expData[3] = 16'hFFEE;
        bpBytes = '{8'h00, 8'h04, 8'hC0, 8'hDE, 8'h5A, 8'h5A, 8'h01, 8'h02, 8'hFF, 8'hEE};
        clearLog();
        startLoad();
        for (int i = 0; i < 10; i++) begin
            gaps = (i == 3) ? 2 : int'($urandom_range(0, 3));
            for (int g = 0; g < gaps; g++) begin
                applyStimulus((i == 3 && g == 0), 1'b0, 8'($urandom));
                stepCycle();
            end
            sendByte(bpBytes[i]);
        end
        byteValid = 1'b0;
        stepCycle();
        checkOutput("bpDone", 32'(loadDone), 32'd1);
        checkOutput("bpWords", 32'(wordsLoaded), 32'd4);
        verifyWrites("bp", 4);

        // Reset mid-load, then a one-word reload
        $display("[TB] reset mid-load");
        clearLog();
        startLoad();
        sendByte(8'h00);
        sendByte(8'h03);
        sendByte(8'h11);
        sendByte(8'h22);
        byteValid = 1'b0;
        stepCycle();
        checkOutput("midWrites", 32'(wrAddr.size()), 32'd1);
        checkOutput("midWords", 32'(wordsLoaded), 32'd1);
        #3;
        applyStimulus(1'($urandom), 1'($urandom), 8'($urandom));
        rstN = 1'b0;
        #1;
        checkAllZero("midRst");
        stepCycle();
        applyStimulus(1'b0, 1'b0, 8'h00);
        rstN = 1'b1;
        stepCycle();
        checkOutput("midDoneLow", 32'(loadDone), 32'd0);
        expData[0] = 16'hBEEF;
        clearLog();
        startLoad();
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'hBE);
        sendByte(8'hEF);
        byteValid = 1'b0;
        stepCycle();
        checkOutput("reloadDone", 32'(loadDone), 32'd1);
        checkOutput("reloadWords", 32'(wordsLoaded), 32'd1);
        verifyWrites("reload", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory read by the fetch unit. It accepts a byte stream over a valid/ready handshake: a 16-bit big-endian word count followed by that many 16-bit big-endian instructions. Each instruction is written to consecutive instruction-memory addresses starting at 0. `load_done` releases the CPU/fetch pair once the image is complete; `error` flags an oversized image.

## Interface
- `ADDR_W`, default 8: instruction-memory address width; memory depth is DEPTH = 2**ADDR_W words.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begin a load; sampled only in IDLE, DONE or ERR.
- `byte_in`, input, 8: stream byte.
- `byte_valid`, input, 1: `byte_in` is valid.
- `byte_ready`, output, 1: loader can accept a byte this cycle.
- `mem_we`, output, 1: instruction-memory write strobe, one cycle per word.
- `mem_addr`, output, ADDR_W: write address.
- `mem_wdata`, output, 16: write data.
- `words_loaded`, output, ADDR_W+1: number of words written in the current load.
- `load_done`, output, 1: image complete; held until the next `start` or reset.
- `error`, output, 1: header count exceeds DEPTH; held until the next `start` or reset.

## Operation
- A byte transfer occurs on a rising edge with `byte_valid` && `byte_ready`. No byte is consumed otherwise. `byte_in` is don't-care when `byte_valid` is low.
- The loader is an FSM with states IDLE, HDR_HI, HDR_LO, DATA_HI, DATA_LO, WRITE, DONE and ERR.
- `byte_ready` = 1 only in HDR_HI, HDR_LO, DATA_HI and DATA_LO.
- **IDLE, DONE, ERR:** `start` = 1 moves to HDR_HI. On that edge, `load_done`, `error`, `words_loaded` and the word index are cleared.
- **HDR_HI:** an accepted byte becomes count[15:8]; go to HDR_LO.
- **HDR_LO:** an accepted byte becomes count[7:0]. Then branch on count:
  - count == 0: go to DONE.
  - count > DEPTH: go to ERR.
  - otherwise: go to DATA_HI.
- **DATA_HI:** an accepted byte is latched as hi; go to DATA_LO.
- **DATA_LO:** on an accepted byte:
  - `mem_wdata` <= {hi, byte_in}.
  - `mem_addr` <= index.
  - go to WRITE.
- **WRITE:** `mem_we` = 1 for exactly this cycle; `byte_ready` = 0. On exit, index and `words_loaded` increment. If the new index == count, go to DONE; else go to DATA_HI.
- **DONE:** `load_done` = 1. Stray bytes are not accepted.
- **ERR:** `error` = 1; no memory writes occur.
- `start` in any other state is ignored. A load cannot be aborted except by reset.
- count == DEPTH is legal; the last address is DEPTH-1, so `mem_addr` never wraps.
- The count comparison uses the full 16 bits, zero-extended against DEPTH.

## Timing
- **Reset (`reset` low, asynchronous):**
  - state = IDLE.
  - `byte_ready`, `mem_we`, `load_done`, `error` = 0.
  - `mem_addr`, `mem_wdata`, `words_loaded` = 0.
  - These values are held while `reset` is low.
- Reset mid-load abandons the image: memory keeps the partial contents, and `load_done` stays 0 until a full reload.
- `start` sampled at edge k puts the FSM in HDR_HI in cycle k+1, with `byte_ready` = 1.
- If DATA_LO accepts at edge k, then in cycle k+1 `mem_we` = 1 with the final `mem_addr` and `mem_wdata`. `words_loaded` increments at edge k+1.
- `mem_addr` and `mem_wdata` remain stable after the write until the next DATA_LO acceptance.
- Peak throughput is one word per 3 cycles: hi byte, lo byte, write.
- `load_done` / `error` rise in the cycle after the final WRITE / HDR_LO edge.
- A `byte_valid` held high during WRITE is not consumed; the upstream byte stays pending.

## Test plan
- **Reset values:** assert `reset` = 0 mid-cycle with random inputs -> all outputs 0 immediately (asynchronous) and stay 0 until release.
- **Basic 3-word load:** `start`, then bytes 00 03 12 34 AB CD 00 01 with `byte_valid` always high -> `mem_we` pulses at addr 0/1/2 with data 0x1234/0xABCD/0x0001, spaced 3 cycles apart; then `load_done` = 1 and `words_loaded` = 3.
- **Empty image:** `start`, bytes 00 00 -> no `mem_we`; `load_done` = 1 one cycle after the second byte; `words_loaded` = 0.
- **Oversize image (ADDR_W = 4):**
  - bytes 00 11 -> `error` = 1, `byte_ready` = 0, no writes.
  - a new `start` with 00 10 plus 16 words -> 16 writes at addr 0..15, `load_done` = 1.
- **Backpressure and gaps:** `byte_valid` toggled randomly and held high across WRITE cycles -> each byte consumed exactly once; written data matches the stream order.
- **Reset mid-load:** assert reset after the first word is written, then reload 00 01 BE EF -> a single write of 0xBEEF at addr 0, `load_done` = 1, `words_loaded` = 1.
